// File: rtl/term_pkg.sv
// rtl/term_pkg.sv - character constants, FSM state type and width helper for the terminal cursor controller
package term_pkg;

  localparam logic [7:0] CHAR_BS  = 8'h08;
  localparam logic [7:0] CHAR_LF  = 8'h0A;
  localparam logic [7:0] CHAR_CR  = 8'h0D;
  localparam logic [7:0] CHAR_SP  = 8'h20;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROWCLR = 2'd1,
    ALLCLR = 2'd2
  } state_t;

  // Address width for n entries, never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/term_sweep_cnt.sv
// rtl/term_sweep_cnt.sv - row/column sweep address generator for row and full-screen clears
module term_sweep_cnt
  import term_pkg::*;
#(
  parameter int COLS = 32,
  parameter int ROWS = 4,
  localparam int ROW_W = addr_w(ROWS),
  localparam int COL_W = addr_w(COLS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             row_only,
  input  logic             restart,
  input  logic             en,
  input  logic [ROW_W-1:0] start_row,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             done
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  logic single;

  // Current address is the final cell of the active sweep.
  assign done = (col == COL_LAST) && (single || (row == ROW_LAST));

  // Load on restart (full screen from cell 0) or start (one row), else step row-major.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      row    <= '0;
      col    <= '0;
      single <= 1'b0;
    end else if (start) begin
      row    <= start_row;
      col    <= '0;
      single <= row_only;
    end else if (en) begin
      if (col == COL_LAST) begin
        col <= '0;
        if (!single) begin
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/term_cursor_ctrl.sv
// rtl/term_cursor_ctrl.sv - byte-stream to text RAM writer with cursor, scroll and clear sweeps
module term_cursor_ctrl
  import term_pkg::*;
#(
  parameter int COLS   = 32,
  parameter int ROWS   = 4,
  parameter int SCROLL = 0,
  localparam int ROW_W = addr_w(ROWS),
  localparam int COL_W = addr_w(COLS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             clr,
  output logic             wr_en,
  output logic [ROW_W-1:0] wr_row,
  output logic [COL_W-1:0] wr_col,
  output logic [7:0]       wr_data,
  output logic [ROW_W-1:0] cur_row,
  output logic [COL_W-1:0] cur_col,
  output logic [ROW_W-1:0] top_row,
  output logic             busy,
  output logic             ovr
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  state_t state;
  logic   cr_seen;

  logic is_print, is_bs, is_cr, is_lf, take;
  logic newline, scroll, do_wr;
  logic [ROW_W-1:0] row_n, top_n, wrow_n, sw_row_start, sw_row;
  logic [COL_W-1:0] col_n, wcol_n, sw_col;
  logic [7:0]       wdata_n;
  logic             sw_done;

  // Logical row r under top row t maps to this physical RAM row.
  function automatic logic [ROW_W-1:0] phys(input logic [ROW_W-1:0] t, input logic [ROW_W-1:0] r);
    int sum;
    sum = int'(t) + int'(r);
    if (sum > ROWS - 1) sum = sum - ROWS;
    return ROW_W'(sum);
  endfunction

  assign busy     = (state != IDLE);
  assign is_print = (rx_data >= PRINT_LO) && (rx_data <= PRINT_HI);
  assign is_bs    = (rx_data == CHAR_BS);
  assign is_cr    = (rx_data == CHAR_CR);
  assign is_lf    = (rx_data == CHAR_LF);
  assign take     = (state == IDLE) && rx_valid && !clr;

  // After a scroll the new bottom row sits just above the new top row.
  assign sw_row_start = phys(top_n, ROW_LAST);

  // Decode the accepted byte into the write it causes and the next cursor/top position.
  always_comb begin
    row_n   = cur_row;
    col_n   = cur_col;
    top_n   = top_row;
    do_wr   = 1'b0;
    wdata_n = rx_data;
    wrow_n  = phys(top_row, cur_row);
    wcol_n  = cur_col;
    newline = 1'b0;
    scroll  = 1'b0;
    if (take) begin
      if (is_print) begin
        do_wr = 1'b1;
        if (cur_col == COL_LAST) begin
          newline = 1'b1;
        end else begin
          col_n = cur_col + 1'b1;
        end
      end else if (is_cr || (is_lf && !cr_seen)) begin
        newline = 1'b1;
      end else if (is_bs && ((cur_row != '0) || (cur_col != '0))) begin
        do_wr   = 1'b1;
        wdata_n = CHAR_SP;
        if (cur_col == '0) begin
          row_n = cur_row - 1'b1;
          col_n = COL_LAST;
        end else begin
          col_n = cur_col - 1'b1;
        end
        wrow_n = phys(top_row, row_n);
        wcol_n = col_n;
      end
      if (newline) begin
        col_n = '0;
        if (cur_row != ROW_LAST) begin
          row_n = cur_row + 1'b1;
        end else if (SCROLL == 0) begin
          row_n = '0;
        end else begin
          scroll = 1'b1;
          top_n  = (top_row == ROW_LAST) ? '0 : top_row + 1'b1;
        end
      end
    end
  end

  term_sweep_cnt #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) u_sweep (
    .clk      (clk),
    .reset    (reset),
    .start    (take && scroll),
    .row_only (1'b1),
    .restart  (clr),
    .en       (busy),
    .start_row(sw_row_start),
    .row      (sw_row),
    .col      (sw_col),
    .done     (sw_done)
  );

  // Control FSM: byte handling in IDLE, one space per cycle during clear sweeps.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cur_row <= '0;
      cur_col <= '0;
      top_row <= '0;
      cr_seen <= 1'b0;
      wr_en   <= 1'b0;
      wr_row  <= '0;
      wr_col  <= '0;
      wr_data <= 8'h00;
      ovr     <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      ovr   <= rx_valid && (clr || busy);
      if (clr) begin
        state   <= ALLCLR;
        cur_row <= '0;
        cur_col <= '0;
        top_row <= '0;
        cr_seen <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (take) begin
              cr_seen <= is_cr;
              cur_row <= row_n;
              cur_col <= col_n;
              top_row <= top_n;
              if (do_wr) begin
                wr_en   <= 1'b1;
                wr_row  <= wrow_n;
                wr_col  <= wcol_n;
                wr_data <= wdata_n;
              end
              if (scroll) state <= ROWCLR;
            end
          end
          ROWCLR, ALLCLR: begin
            wr_en   <= 1'b1;
            wr_row  <= sw_row;
            wr_col  <= sw_col;
            wr_data <= CHAR_SP;
            if (sw_done) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
